// File: rtl/jt900h_muldiv_if.sv
// Handshake and operand bundle between the TLCS-900H control unit and the
// sequential multiply/divide unit.
interface jt900h_muldiv_if #(
    parameter int W = 16
);
    logic           start;
    logic [1:0]     op;
    logic           hsz;
    logic [2*W-1:0] a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] rslt;
    logic           v;
    logic           z;
    logic           n;

    modport master (
        output start, op, hsz, a, b,
        input  busy, done, rslt, v, z, n
    );

    modport slave (
        input  start, op, hsz, a, b,
        output busy, done, rslt, v, z, n
    );
endinterface

// File: rtl/jt900h_muldiv.sv
// Sequential MULU/MULS/DIVU/DIVS unit: one result bit per enabled cycle,
// full (N=W) or half (N=W/2) operand size, with overflow and zero/sign flags.
module jt900h_muldiv #(
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cen,
    jt900h_muldiv_if.slave bus
);
    localparam int H  = W / 2;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

    state_t         state_reg, state_next;
    logic [1:0]     op_reg;
    logic           hsz_reg;
    logic [2*W-1:0] a_reg;
    logic [W-1:0]   b_reg;
    logic           sa_reg, sb_reg, err_reg;
    logic [2*W-1:0] acc_reg;    // MUL accumulator; DIV partial remainder in low W bits
    logic [2*W-1:0] sh_reg;     // MUL shifted multiplicand
    logic [W-1:0]   q_reg;      // MUL multiplier (shifts right); DIV dividend/quotient (shifts left)
    logic [W-1:0]   d_reg;
    logic [CW-1:0]  cnt_reg;
    logic [2*W-1:0] rslt_reg;
    logic           v_reg, z_reg, n_reg, done_reg;

    logic           busy, accept;
    logic           is_div, sgn;
    logic [W-1:0]   mask_n;
    logic [2*W-1:0] mask_2n, mask_mul_a;
    logic [2*W-1:0] a_op, a_msk, a_mag;
    logic [W-1:0]   b_lo, b_mag, a_hi, q_init;
    logic           a_sign, b_sign, sa, sb, div_err;
    logic [CW-1:0]  n_val;
    logic [W:0]     r_sh, d_ext, r_sub;
    logic           r_ge;
    logic [2*W-1:0] mul_acc;
    logic           neg_res, q_ovf, ovf;
    logic [2*W-1:0] prod, div_rslt, fix_rslt;
    logic [W-1:0]   quot, rem, lim;
    logic           fix_z, fix_n;

    assign busy     = (state_reg != IDLE) || done_reg;
    assign accept   = bus.start && !busy;
    assign bus.busy = busy;
    assign bus.done = done_reg;
    assign bus.rslt = rslt_reg;
    assign bus.v    = v_reg;
    assign bus.z    = z_reg;
    assign bus.n    = n_reg;

    // Operand preparation: masks, signs and magnitudes over the selected width.
    always_comb begin
        is_div     = op_reg[1];
        sgn        = op_reg[0];
        mask_n     = hsz_reg ? {{H{1'b0}}, {H{1'b1}}} : {W{1'b1}};
        mask_2n    = hsz_reg ? {{W{1'b0}}, {W{1'b1}}} : {(2*W){1'b1}};
        mask_mul_a = hsz_reg ? {{(W+H){1'b0}}, {H{1'b1}}} : {{W{1'b0}}, {W{1'b1}}};
        n_val      = hsz_reg ? CW'(H) : CW'(W);

        // The multiplicand is N bits wide, the dividend 2N bits.
        a_sign = is_div ? (hsz_reg ? a_reg[W-1] : a_reg[2*W-1])
                        : (hsz_reg ? a_reg[H-1] : a_reg[W-1]);
        b_sign = hsz_reg ? b_reg[H-1] : b_reg[W-1];
        sa     = sgn & a_sign;
        sb     = sgn & b_sign;

        a_msk  = is_div ? mask_2n : mask_mul_a;
        a_op   = a_reg & a_msk;
        a_mag  = (sa ? -a_op : a_op) & a_msk;
        b_lo   = b_reg & mask_n;
        b_mag  = (sb ? -b_lo : b_lo) & mask_n;

        a_hi    = hsz_reg ? {{H{1'b0}}, a_mag[W-1:H]} : a_mag[2*W-1:W];
        q_init  = hsz_reg ? {a_mag[H-1:0], {H{1'b0}}} : a_mag[W-1:0];
        div_err = is_div && ((b_lo == '0) || (a_hi >= b_mag));
    end

    // One iteration step for each operation class.
    always_comb begin
        r_sh    = {acc_reg[W-1:0], q_reg[W-1]};
        d_ext   = {1'b0, d_reg};
        r_ge    = (r_sh >= d_ext);
        r_sub   = r_sh - d_ext;
        mul_acc = acc_reg + (q_reg[0] ? sh_reg : {(2*W){1'b0}});
    end

    // Sign fix-up, range check and flag generation for the final cycle.
    always_comb begin
        neg_res  = sa_reg ^ sb_reg;
        prod     = (neg_res ? -acc_reg : acc_reg) & mask_2n;
        quot     = (neg_res ? -q_reg : q_reg) & mask_n;
        rem      = (sa_reg ? -acc_reg[W-1:0] : acc_reg[W-1:0]) & mask_n;
        lim      = {{(W-1){1'b0}}, 1'b1} << (n_val - CW'(1));
        // A negative quotient may reach -2^(N-1); a positive one stops at 2^(N-1)-1.
        q_ovf    = sgn && (neg_res ? (q_reg > lim) : (q_reg >= lim));
        ovf      = is_div && (err_reg || q_ovf);
        div_rslt = hsz_reg ? {{W{1'b0}}, rem[H-1:0], quot[H-1:0]} : {rem, quot};
        fix_rslt = ovf ? (a_reg & mask_2n) : (is_div ? div_rslt : prod);
        fix_z    = !ovf && (is_div ? (quot == '0) : (prod == '0));
        fix_n    = !ovf && (is_div ? (hsz_reg ? quot[H-1] : quot[W-1])
                                   : (hsz_reg ? prod[W-1] : prod[2*W-1]));
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = PREP;
            PREP:    state_next = div_err ? FIX : ITER;
            ITER:    if (cnt_reg == CW'(1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            op_reg    <= '0;
            hsz_reg   <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sa_reg    <= 1'b0;
            sb_reg    <= 1'b0;
            err_reg   <= 1'b0;
            acc_reg   <= '0;
            sh_reg    <= '0;
            q_reg     <= '0;
            d_reg     <= '0;
            cnt_reg   <= '0;
            rslt_reg  <= '0;
            v_reg     <= 1'b0;
            z_reg     <= 1'b0;
            n_reg     <= 1'b0;
            done_reg  <= 1'b0;
        end else if (cen) begin
            state_reg <= state_next;
            done_reg  <= (state_reg == FIX);
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        op_reg  <= bus.op;
                        hsz_reg <= bus.hsz;
                        a_reg   <= bus.a;
                        b_reg   <= bus.b;
                    end
                end
                PREP: begin
                    sa_reg  <= sa;
                    sb_reg  <= sb;
                    err_reg <= div_err;
                    cnt_reg <= n_val;
                    d_reg   <= b_mag;
                    sh_reg  <= a_mag;
                    acc_reg <= is_div ? {{W{1'b0}}, a_hi} : {(2*W){1'b0}};
                    q_reg   <= is_div ? q_init : b_mag;
                end
                ITER: begin
                    cnt_reg <= cnt_reg - CW'(1);
                    if (is_div) begin
                        acc_reg <= {{W{1'b0}}, r_ge ? r_sub[W-1:0] : r_sh[W-1:0]};
                        q_reg   <= {q_reg[W-2:0], r_ge};
                    end else begin
                        acc_reg <= mul_acc;
                        sh_reg  <= {sh_reg[2*W-2:0], 1'b0};
                        q_reg   <= {1'b0, q_reg[W-1:1]};
                    end
                end
                FIX: begin
                    rslt_reg <= fix_rslt;
                    v_reg    <= ovf;
                    z_reg    <= fix_z;
                    n_reg    <= fix_n;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_jt900h_muldiv.sv
// Scoreboard bench for jt900h_muldiv: directed vectors queue their expected
// response; an independent monitor checks each done pulse against the queue.
module tb_jt900h_muldiv;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cen = 1'b1;

    jt900h_muldiv_if #(.W(W)) bus ();

    jt900h_muldiv #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cen   (cen),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] rslt;
        logic        v;
        logic        z;
        logic        n;
        logic        chk_zn;
        int          lat;
        int          acc_cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   resp_cnt = 0;
    int   n_exp = 0;
    logic done_q = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Monitor: one check set per rising done pulse.
    always @(negedge clk) begin
        if (bus.done && !done_q) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got rslt=%h with no request pending", bus.rslt);
            end else begin
                mon_e = sb_q.pop_front();
                $display("txn %0d: rslt=%h v=%b z=%b n=%b latency=%0d",
                         mon_e.id, bus.rslt, bus.v, bus.z, bus.n, cyc - mon_e.acc_cyc);
                check($sformatf("txn%0d_rslt", mon_e.id), bus.rslt, mon_e.rslt);
                check($sformatf("txn%0d_v", mon_e.id), 32'(bus.v), 32'(mon_e.v));
                check($sformatf("txn%0d_latency", mon_e.id), cyc - mon_e.acc_cyc, mon_e.lat);
                check($sformatf("txn%0d_busy_on_done", mon_e.id), 32'(bus.busy), 32'd1);
                if (mon_e.chk_zn) begin
                    check($sformatf("txn%0d_z", mon_e.id), 32'(bus.z), 32'(mon_e.z));
                    check($sformatf("txn%0d_n", mon_e.id), 32'(bus.n), 32'(mon_e.n));
                end
                resp_cnt++;
            end
        end
        done_q <= bus.done;
    end

    // Drives a request at a negedge; it is accepted on the following posedge.
    task automatic issue(input logic [1:0] op, input logic h, input logic [31:0] a,
                         input logic [15:0] b, input logic [31:0] er, input logic ev,
                         input logic ez, input logic en, input logic czn, input int lat);
        exp_t e;
        for (int i = 0; i < 50 && bus.busy; i++) @(negedge clk);
        bus.op    = op;
        bus.hsz   = h;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        e.id      = n_exp;
        e.rslt    = er;
        e.v       = ev;
        e.z       = ez;
        e.n       = en;
        e.chk_zn  = czn;
        e.lat     = lat;
        e.acc_cyc = cyc + 1;
        sb_q.push_back(e);
        n_exp++;
    endtask

    task automatic wait_resp(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (resp_cnt >= n_exp) break;
            @(negedge clk);
        end
        if (resp_cnt < n_exp) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d responses, expected %0d", resp_cnt, n_exp);
            sb_q.delete();
            resp_cnt = n_exp;
        end
        @(negedge clk);
    endtask

    task automatic run(input logic [1:0] op, input logic h, input logic [31:0] a,
                       input logic [15:0] b, input logic [31:0] er, input logic ev,
                       input logic ez, input logic en, input logic czn, input int lat);
        issue(op, h, a, b, er, ev, ez, en, czn, lat);
        @(negedge clk);
        bus.start = 1'b0;
        wait_resp(60);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.start = 1'b0;
        bus.op    = 2'd0;
        bus.hsz   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_rslt", bus.rslt, 32'd0);
        check("reset_vzn", {29'd0, bus.v, bus.z, bus.n}, 32'd0);

        //   op    hsz   a             b         rslt          v     z     n     zn    lat
        run(2'd0, 1'b0, 32'h0000FFFF, 16'hFFFF, 32'hFFFE0001, 1'b0, 1'b0, 1'b1, 1'b1, 18);
        run(2'd1, 1'b1, 32'h00000080, 16'h0002, 32'h0000FF00, 1'b0, 1'b0, 1'b1, 1'b1, 10);
        run(2'd2, 1'b0, 32'h00012345, 16'h0010, 32'h00051234, 1'b0, 1'b0, 1'b0, 1'b1, 18);
        run(2'd3, 1'b0, 32'hFFFFFFF9, 16'h0002, 32'hFFFFFFFD, 1'b0, 1'b0, 1'b1, 1'b1, 18);
        run(2'd2, 1'b0, 32'h00001234, 16'h0000, 32'h00001234, 1'b1, 1'b0, 1'b0, 1'b0, 2);
        run(2'd2, 1'b0, 32'h00020000, 16'h0001, 32'h00020000, 1'b1, 1'b0, 1'b0, 1'b0, 2);
        run(2'd3, 1'b0, 32'h00008000, 16'h0001, 32'h00008000, 1'b1, 1'b0, 1'b0, 1'b0, 18);
        run(2'd3, 1'b0, 32'hFFFF8000, 16'h0001, 32'h00008000, 1'b0, 1'b0, 1'b1, 1'b1, 18);
        run(2'd0, 1'b0, 32'h00001234, 16'h0000, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b1, 18);
        run(2'd1, 1'b0, 32'h0000FFFF, 16'h0003, 32'hFFFFFFFD, 1'b0, 1'b0, 1'b1, 1'b1, 18);
        run(2'd2, 1'b1, 32'h00000064, 16'h0007, 32'h0000020E, 1'b0, 1'b0, 1'b0, 1'b1, 10);
        run(2'd3, 1'b1, 32'hABCDFF9C, 16'h1207, 32'h0000FEF2, 1'b0, 1'b0, 1'b1, 1'b1, 10);

        // Clock enable toggling every clock doubles the latency.
        issue(2'd0, 1'b0, 32'h00001234, 16'h5678, 32'h06260060, 1'b0, 1'b0, 1'b0, 1'b1, 36);
        for (int i = 0; i < 90 && resp_cnt < n_exp; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            cen = ~cen;
        end
        cen = 1'b1;
        wait_resp(5);

        // Start held high through the whole operation and its done cycle is ignored;
        // a start on the following idle cycle is taken.
        issue(2'd0, 1'b0, 32'h0000FFFF, 16'hFFFF, 32'hFFFE0001, 1'b0, 1'b0, 1'b1, 1'b1, 18);
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            bus.start = 1'b1;
            bus.op    = 2'd0;
            bus.a     = 32'h00000002;
            bus.b     = 16'h0002;
        end
        @(negedge clk);
        issue(2'd0, 1'b0, 32'h00000007, 16'h0009, 32'h0000003F, 1'b0, 1'b0, 1'b0, 1'b1, 18);
        @(negedge clk);
        bus.start = 1'b0;
        wait_resp(60);
        repeat (25) @(negedge clk);
        check("idle_after_handshake_busy", 32'(bus.busy), 32'd0);

        // Reset in the middle of the iteration phase.
        issue(2'd0, 1'b0, 32'h0000FFFF, 16'hFFFF, 32'hFFFE0001, 1'b0, 1'b0, 1'b1, 1'b1, 18);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midop_reset_busy", 32'(bus.busy), 32'd0);
        check("midop_reset_rslt", bus.rslt, 32'd0);
        check("midop_reset_done", 32'(bus.done), 32'd0);
        sb_q.delete();
        n_exp = resp_cnt;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run(2'd0, 1'b0, 32'h00000003, 16'h0005, 32'h0000000F, 1'b0, 1'b0, 1'b0, 1'b1, 18);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
